// File: rtl/imem_loader_if.sv
// Stream-in and instruction-memory write bundle for the program loader.
// The master side feeds bytes and start; the slave side is the loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned WORD_WIDTH = 16
);
  logic                  start;
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [WORD_WIDTH-1:0] imem_wdata;
  logic                  cpu_hold;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [ADDR_WIDTH:0]   words_loaded;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata,
    input  cpu_hold, busy, done, error, words_loaded
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata,
    output cpu_hold, busy, done, error, words_loaded
  );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream loader: COUNT, N big-endian words, XOR checksum.
// Writes words to imem from address 0 and holds the CPU for the whole load.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned WORD_WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_HI, S_LO, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            chk_q, chk_d;
  logic [7:0]            hi_q, hi_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         n_q, n_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic                  in_ready_q, in_ready_d;
  logic                  we_q, we_d;
  logic                  hold_q, hold_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  xfer_c;

  // in_ready_q mirrors the current state, so a transfer never depends on in_valid timing
  assign xfer_c = bus.in_valid && in_ready_q;

  always_comb begin
    state_d = state_q;
    chk_d   = chk_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    unique case (state_q)
      S_IDLE, S_ERROR: begin
        if (bus.start) begin
          state_d = S_COUNT;
          chk_d   = 8'd0;
          cnt_d   = CW'(0);
        end
      end
      S_COUNT: begin
        if (xfer_c) begin
          chk_d = chk_q ^ bus.in_data;
          n_d   = CW'(bus.in_data);
          if (bus.in_data == 8'd0 || 32'(bus.in_data) > DEPTH) state_d = S_ERROR;
          else                                                 state_d = S_HI;
        end
      end
      S_HI: begin
        if (xfer_c) begin
          hi_d    = bus.in_data;
          chk_d   = chk_q ^ bus.in_data;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (xfer_c) begin
          chk_d   = chk_q ^ bus.in_data;
          addr_d  = cnt_q[ADDR_WIDTH-1:0];
          wdata_d = WORD_WIDTH'({hi_q, bus.in_data});
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q + CW'(1) == n_q) ? S_CHECK : S_HI;
      end
      S_CHECK: begin
        if (xfer_c) state_d = (bus.in_data == chk_q) ? S_DONE : S_ERROR;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered decodes of the state being entered
    in_ready_d = (state_d == S_COUNT) || (state_d == S_HI) ||
                 (state_d == S_LO)    || (state_d == S_CHECK);
    we_d       = (state_d == S_WRITE);
    hold_d     = (state_d != S_IDLE);
    busy_d     = (state_d != S_IDLE) && (state_d != S_ERROR);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERROR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      chk_q      <= 8'd0;
      hi_q       <= 8'd0;
      cnt_q      <= CW'(0);
      n_q        <= CW'(0);
      addr_q     <= '0;
      wdata_q    <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      hold_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      chk_q      <= chk_d;
      hi_q       <= hi_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.imem_we      = we_q;
  assign bus.imem_addr    = addr_q;
  assign bus.imem_wdata   = wdata_q;
  assign bus.cpu_hold     = hold_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.error        = err_q;
  assign bus.words_loaded = cnt_q;
endmodule
